io_bus_arbiter: RTL and testbench

//  Round-robin arbiter for the shared IO bus (addr/ctrl/inout data) feeding the RAM
//  and peripheral interfaces. Takes bus requests from N masters (CPU data port,
//  DMA, debug, ...) and issues a one-hot grant. Drives the BG bus-grant line seen
//  by every IO interface. Enforces a bounded hold time and a one-cycle turnaround

---
 rtl/io_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_io_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_arbiter
//  Purpose  : Round-robin arbiter for the shared IO bus. Issues a registered
//             one-hot grant to one of N_MASTER requesters, bounds how long an
//             owner may keep the bus while others wait, and inserts one dead
//             (turnaround) cycle between successive owners so inout data
//             drivers never overlap.
//  Ports    : clk    - system clock, rising edge
//             rst    - synchronous active-high reset
//             req    - per-master level request [N_MASTER]
//             gnt    - registered one-hot (or zero) grant [N_MASTER]
//             BG     - bus grant to the IO interfaces, equals |gnt
//             owner  - index of current/last granted master [ID_W]
//             busy   - high whenever the FSM is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module io_bus_arbiter #(
    parameter int N_MASTER = 4,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MASTER-1:0] req,
    output logic [N_MASTER-1:0] gnt,
    output logic                BG,
    output logic [ID_W-1:0]     owner,
    output logic                busy
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam int IDX_W = ID_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [N_MASTER-1:0] r_gnt,      w_gnt_nxt;
    logic [ID_W-1:0]     r_owner,    w_owner_nxt;
    logic [ID_W-1:0]     r_rr_ptr,   w_rr_ptr_nxt;
    logic [CNT_W-1:0]    r_hold_cnt, w_hold_cnt_nxt;

    logic [ID_W-1:0]     w_win;
    logic                w_any;
    logic                w_others;
    logic                w_hold_sat;
    logic                w_release;
    logic [ID_W-1:0]     w_owner_inc;

    // Round-robin search starting at r_rr_ptr. The index is computed one bit
    // wider than ID_W so the wrap works for non-power-of-two N_MASTER.
    always_comb begin : p_arb
        logic [IDX_W-1:0] v_idx;
        v_idx = '0;
        w_win = '0;
        w_any = 1'b0;
        for (int i = 0; i < N_MASTER; i++) begin
            v_idx = {1'b0, r_rr_ptr} + IDX_W'(i);
            if (v_idx >= IDX_W'(N_MASTER)) begin
                v_idx = v_idx - IDX_W'(N_MASTER);
            end
            if (!w_any && req[v_idx[ID_W-1:0]]) begin
                w_any = 1'b1;
                w_win = v_idx[ID_W-1:0];
            end
        end
    end

    // While granted, r_gnt is exactly the owner's bit, so masking with it
    // leaves only the competing requests.
    assign w_others    = |(req & ~r_gnt);
    assign w_hold_sat  = (r_hold_cnt == CNT_W'(MAX_HOLD));
    assign w_release   = !req[r_owner] || (w_hold_sat && w_others);
    assign w_owner_inc = (r_owner == ID_W'(N_MASTER - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            S_IDLE, S_TURN: begin
                if (w_any) begin
                    w_state_nxt    = S_GRANT;
                    w_gnt_nxt      = N_MASTER'(1) << w_win;
                    w_owner_nxt    = w_win;
                    w_hold_cnt_nxt = CNT_W'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_state_nxt  = S_TURN;
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = w_owner_inc;
                end else if (!w_hold_sat) begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign BG    = |r_gnt;
    assign owner = r_owner;
    assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_bus_arbiter
//  Purpose  : Self-checking bench for io_bus_arbiter. A table of directed
//             {req, expected outputs} vectors covers grant latency, hold,
//             release, turnaround and round-robin order; hand-written
//             sequences cover hold-time rotation, the lone-requester case,
//             reset during a grant and a 3-master configuration.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       bg;
    logic [1:0] owner;
    logic       busy;

    logic [2:0] req3;
    logic [2:0] gnt3;
    logic       bg3;
    logic [1:0] owner3;
    logic       busy3;

    int checks = 0;
    int errors = 0;
    int inv_bad = 0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.N_MASTER(4), .MAX_HOLD(16), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .BG(bg), .owner(owner), .busy(busy)
    );

    io_bus_arbiter #(.N_MASTER(3), .MAX_HOLD(3), .ID_W(2)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .gnt(gnt3), .BG(bg3), .owner(owner3), .busy(busy3)
    );

    // Invariants: at most one grant bit, BG tracks |gnt.
    always @(negedge clk) begin
        if ($countones(gnt) > 1 || bg != |gnt) inv_bad++;
        if ($countones(gnt3) > 1 || bg3 != |gnt3) inv_bad++;
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       bg;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        req3 = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int run;
        int cnt_bad;
        int ng;
        logic [1:0] g3[4];
        logic prev_bg3;

        rst  = 1'b1;
        req  = '0;
        req3 = '0;

        //            req      gnt      bg    owner busy
        vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
        vecs[2]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
        vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1};
        vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[5]  = '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1};
        vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[8]  = '{4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1};
        vecs[9]  = '{4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1};
        vecs[10] = '{4'b1000, 4'b0000, 1'b0, 2'd1, 1'b1};
        vecs[11] = '{4'b1000, 4'b1000, 1'b1, 2'd3, 1'b1};
        vecs[12] = '{4'b1001, 4'b1000, 1'b1, 2'd3, 1'b1};
        vecs[13] = '{4'b0001, 4'b0000, 1'b0, 2'd3, 1'b1};
        vecs[14] = '{4'b0011, 4'b0001, 1'b1, 2'd0, 1'b1};

        // ---- reset state ----
        step();
        step();
        chk("rst_gnt",   gnt,   0);
        chk("rst_bg",    bg,    0);
        chk("rst_owner", owner, 0);
        chk("rst_busy",  busy,  0);
        chk("rst_gnt3",  gnt3,  0);
        rst = 1'b0;

        // ---- table-driven vectors ----
        for (int v = 0; v < 15; v++) begin
            req = vecs[v].req;
            step();
            chk($sformatf("vec%0d_gnt", v),   gnt,   vecs[v].gnt);
            chk($sformatf("vec%0d_bg", v),    bg,    vecs[v].bg);
            chk($sformatf("vec%0d_owner", v), owner, vecs[v].owner);
            chk($sformatf("vec%0d_busy", v),  busy,  vecs[v].busy);
        end

        // ---- all four requesting: 16-cycle slots, 1 dead cycle, 0,1,2,3,0 ----
        do_reset();
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (g % 4);
            run = 0;
            while (gnt == exp_g && run < 40) begin
                run++;
                step();
            end
            chk($sformatf("rot%0d_len", g), run, 16);
            chk($sformatf("rot%0d_turn", g), gnt, 0);
            step();
        end

        // ---- lone requester keeps bus; newcomer preempts saturated owner ----
        do_reset();
        req = 4'b0010;
        cnt_bad = 0;
        for (int c = 0; c < 49; c++) begin
            step();
            if (gnt != 4'b0010) cnt_bad++;
        end
        chk("lone_hold", cnt_bad, 0);
        req = 4'b1010;
        step();
        chk("lone_release_gnt",  gnt,  0);
        chk("lone_release_busy", busy, 1);
        step();
        chk("lone_next_gnt",   gnt,   4'b1000);
        chk("lone_next_owner", owner, 3);

        // ---- reset during a grant clears rr_ptr ----
        do_reset();
        req = 4'b0011;
        step();
        chk("mrst_g0", gnt, 4'b0001);
        req = 4'b0010;
        step();
        step();
        chk("mrst_g1", gnt, 4'b0010);
        req = 4'b0011;
        step();
        rst = 1'b1;
        step();
        chk("mrst_gnt",   gnt,   0);
        chk("mrst_bg",    bg,    0);
        chk("mrst_owner", owner, 0);
        chk("mrst_busy",  busy,  0);
        rst = 1'b0;
        step();
        chk("mrst_after_gnt", gnt, 4'b0001);

        // ---- 3-master instance: req=101 rotates 0,2,0,2 ----
        do_reset();
        req3 = 3'b101;
        ng = 0;
        cnt_bad = 0;
        prev_bg3 = 1'b0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            step();
            if (bg3 && owner3 == 2'd3) cnt_bad++;
            if (bg3 && !prev_bg3) begin
                g3[ng] = owner3;
                ng++;
            end
            prev_bg3 = bg3;
        end
        chk("n3_count", ng, 4);
        if (ng == 4) begin
            chk("n3_g0", g3[0], 0);
            chk("n3_g1", g3[1], 2);
            chk("n3_g2", g3[2], 0);
            chk("n3_g3", g3[3], 2);
        end
        chk("n3_no_idx3", cnt_bad, 0);

        req  = '0;
        req3 = '0;
        step();
        chk("invariants", inv_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
